// File: rtl/dino_pkg.sv
// rtl/dino_pkg.sv - shared game state type, colours and frame geometry defaults
package dino_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        OVER    = 2'd2
    } game_state_t;

    localparam logic [8:0]  DEF_LAST_ROW       = 9'd479;
    localparam logic [9:0]  DEF_LAST_COL       = 10'd639;
    localparam logic [5:0]  DEF_HOLDOFF_FRAMES = 6'd30;
    localparam logic [11:0] DEF_FG_RGB         = 12'h555;
    localparam logic [11:0] DEF_BG_RGB         = 12'hFFF;

endpackage

// File: rtl/frame_compositor_frame_boundary.sv
// rtl/frame_compositor_frame_boundary.sv - last-visible-pixel detect and registered frame_tick
module frame_boundary
    import dino_pkg::*;
#(
    parameter logic [8:0] LAST_ROW = DEF_LAST_ROW,
    parameter logic [9:0] LAST_COL = DEF_LAST_COL
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [8:0] i_row_addr,
    input  logic [9:0] i_col_addr,
    output logic       o_at_last,
    output logic       o_frame_tick
);

    logic r_frame_tick;

    // Full-width compare: out-of-range addresses never alias onto the last pixel
    assign o_at_last    = (i_row_addr == LAST_ROW) && (i_col_addr == LAST_COL);
    assign o_frame_tick = r_frame_tick;

    // frame_tick trails the last-pixel input cycle by one clock
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= o_at_last;
        end
    end

endmodule

// File: rtl/frame_compositor.sv
// rtl/frame_compositor.sv - pixel merge, overlap detect and game FSM (optional GAMEOVER_FLASH_EN)
module frame_compositor
    import dino_pkg::*;
#(
    parameter logic [8:0]  LAST_ROW       = DEF_LAST_ROW,
    parameter logic [9:0]  LAST_COL       = DEF_LAST_COL,
    parameter logic [5:0]  HOLDOFF_FRAMES = DEF_HOLDOFF_FRAMES,
    parameter logic [11:0] FG_RGB         = DEF_FG_RGB,
    parameter logic [11:0] BG_RGB         = DEF_BG_RGB
) (
    input  logic        CLK,
    input  logic        N_rst,
    input  logic [8:0]  row_addr,
    input  logic [9:0]  col_addr,
    input  logic        video_on,
    input  logic        ground_px,
    input  logic        dino_px,
    input  logic        obstacle_px,
    input  logic        start_btn,
    output logic        game_status,
    output logic        collision,
    output logic        frame_tick,
    output logic [11:0] rgb
);

    game_state_t r_state;
    game_state_t w_state_next;
    logic        r_btn_q;
    logic        r_start_pend;
    logic        r_hit_flag;
    logic [5:0]  r_holdoff;
    logic        r_collision;
    logic        r_game_status;
    logic [11:0] r_rgb;

    logic w_boundary;
    logic w_start_rise;
    logic w_press_ok;
    logic w_hit_now;
    logic w_fg;
    logic w_swap;

    frame_boundary #(
        .LAST_ROW (LAST_ROW),
        .LAST_COL (LAST_COL)
    ) u_frame_boundary (
        .i_clk        (CLK),
        .i_rst_n      (N_rst),
        .i_row_addr   (row_addr),
        .i_col_addr   (col_addr),
        .o_at_last    (w_boundary),
        .o_frame_tick (frame_tick)
    );

    assign w_start_rise = start_btn & ~r_btn_q;
    assign w_hit_now    = video_on & dino_px & obstacle_px;
    // A press only counts in IDLE, or in OVER once the holdoff has drained
    assign w_press_ok   = w_start_rise &
                          ((r_state == IDLE) || ((r_state == OVER) && (r_holdoff == 6'd0)));
    assign w_fg         = ground_px | dino_px | obstacle_px;

`ifdef GAMEOVER_FLASH_EN
    logic [4:0] r_flash_cnt;

    // Frames spent in OVER; restarts from zero each time the game ends
    always_ff @(posedge CLK) begin
        if (!N_rst) begin
            r_flash_cnt <= 5'd0;
        end else if (w_boundary) begin
            if ((r_state == RUNNING) && (w_state_next == OVER)) begin
                r_flash_cnt <= 5'd0;
            end else if (r_state == OVER) begin
                r_flash_cnt <= r_flash_cnt + 5'd1;
            end
        end
    end

    assign w_swap = (r_state == OVER) && r_flash_cnt[4];
`else
    assign w_swap = 1'b0;
`endif

    // Next state is only evaluated on the last pixel so a frame renders in one state
    always_comb begin
        w_state_next = r_state;
        if (w_boundary) begin
            case (r_state)
                IDLE:    if (r_start_pend || w_press_ok) w_state_next = RUNNING;
                RUNNING: if (r_hit_flag || w_hit_now)   w_state_next = OVER;
                OVER:    if (r_start_pend || w_press_ok) w_state_next = RUNNING;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // State register plus the per-frame bookkeeping that rides on it
    always_ff @(posedge CLK) begin
        if (!N_rst) begin
            r_state       <= IDLE;
            r_btn_q       <= 1'b0;
            r_start_pend  <= 1'b0;
            r_hit_flag    <= 1'b0;
            r_holdoff     <= 6'd0;
            r_collision   <= 1'b0;
            r_game_status <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_btn_q       <= start_btn;
            r_game_status <= (w_state_next == RUNNING);
            r_collision   <= (r_state == RUNNING) && (w_state_next == OVER);
            // Pending press and hit are per-frame facts; both drop at the boundary
            if (w_boundary) begin
                r_start_pend <= 1'b0;
                r_hit_flag   <= 1'b0;
            end else begin
                if (w_press_ok) r_start_pend <= 1'b1;
                if ((r_state == RUNNING) && w_hit_now) r_hit_flag <= 1'b1;
            end
            if (w_boundary) begin
                if ((r_state == RUNNING) && (w_state_next == OVER)) begin
                    r_holdoff <= HOLDOFF_FRAMES;
                end else if ((r_state == OVER) && (r_holdoff != 6'd0)) begin
                    r_holdoff <= r_holdoff - 6'd1;
                end
            end
        end
    end

    // Pixel merge: any foreground layer wins over background, blanking forces black
    always_ff @(posedge CLK) begin
        if (!N_rst) begin
            r_rgb <= 12'h000;
        end else if (!video_on) begin
            r_rgb <= 12'h000;
        end else if (w_fg ^ w_swap) begin
            r_rgb <= FG_RGB;
        end else begin
            r_rgb <= BG_RGB;
        end
    end

    assign game_status = r_game_status;
    assign collision   = r_collision;
    assign rgb         = r_rgb;

endmodule

// File: tb/tb_frame_compositor.sv
// tb/tb_frame_compositor.sv - randomized frame-level checks of frame_compositor against a game model
`timescale 1ns/1ps
module tb_frame_compositor;

    logic        CLK = 1'b0;
    logic        N_rst;
    logic [8:0]  row_addr;
    logic [9:0]  col_addr;
    logic        video_on;
    logic        ground_px;
    logic        dino_px;
    logic        obstacle_px;
    logic        start_btn;
    logic        game_status;
    logic        collision;
    logic        frame_tick;
    logic [11:0] rgb;

    frame_compositor dut (
        .CLK         (CLK),
        .N_rst       (N_rst),
        .row_addr    (row_addr),
        .col_addr    (col_addr),
        .video_on    (video_on),
        .ground_px   (ground_px),
        .dino_px     (dino_px),
        .obstacle_px (obstacle_px),
        .start_btn   (start_btn),
        .game_status (game_status),
        .collision   (collision),
        .frame_tick  (frame_tick),
        .rgb         (rgb)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Game model: 0 = idle, 1 = running, 2 = over
    int m_state;
    int m_holdoff;
    int m_flash;
    bit m_press;
    bit m_hit;
    bit m_btn;
    int run_err;

    logic gs_pre, gs_post, coll_post, tick_post;

    task automatic model_reset();
        m_state = 0; m_holdoff = 0; m_flash = 0;
        m_press = 0; m_hit = 0; m_btn = 0;
    endtask

    task automatic do_reset();
        N_rst = 1'b0;
        row_addr = 9'd0; col_addr = 10'd0; video_on = 1'b0;
        ground_px = 1'b0; dino_px = 1'b0; obstacle_px = 1'b0; start_btn = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        N_rst = 1'b1;
        model_reset();
    endtask

    // Drive one pixel, advance the model and note any cycle-level disagreement
    task automatic step(input logic [8:0] r, input logic [9:0] c,
                        input logic v, input logic g, input logic d,
                        input logic o, input logic b);
        logic [11:0] e_rgb;
        logic        e_tick, e_coll, e_gs, swap;
        row_addr = r; col_addr = c; video_on = v;
        ground_px = g; dino_px = d; obstacle_px = o; start_btn = b;
        swap = 1'b0;
`ifdef GAMEOVER_FLASH_EN
        swap = (m_state == 2) && (m_flash >= 16);
`endif
        if (!v)               e_rgb = 12'h000;
        else if ((g | d | o) ^ swap) e_rgb = 12'h555;
        else                  e_rgb = 12'hFFF;
        if (m_state == 1 && v && d && o) m_hit = 1;
        if (b && !m_btn && (m_state == 0 || (m_state == 2 && m_holdoff == 0))) m_press = 1;
        m_btn = b;
        e_tick = (r == 9'd479) && (c == 10'd639);
        e_coll = 1'b0;
        if (e_tick) begin
            case (m_state)
                0: if (m_press) m_state = 1;
                1: if (m_hit) begin
                       m_state = 2; m_holdoff = 30; m_flash = 0; e_coll = 1'b1;
                   end
                default: begin
                    m_flash = (m_flash + 1) % 32;
                    if (m_holdoff > 0) m_holdoff--;
                    if (m_press) m_state = 1;
                end
            endcase
            m_press = 0;
            m_hit = 0;
        end
        e_gs = (m_state == 1);
        @(posedge CLK);
        #1;
        if (rgb !== e_rgb || frame_tick !== e_tick || collision !== e_coll || game_status !== e_gs) begin
            run_err++;
            if (run_err <= 5)
                $display("detail: cycle disagreement rgb=%h/%h tick=%b/%b coll=%b/%b gs=%b/%b",
                         rgb, e_rgb, frame_tick, e_tick, collision, e_coll, game_status, e_gs);
        end
    endtask

    // Compressed frame: n random pixels (never the last one) then the boundary pixel
    task automatic run_frame(input int n, input int press_at, input int hit_at);
        logic [8:0] r;
        logic [9:0] c;
        logic       v, g, d, o, b;
        int         sel;
        for (int i = 0; i < n; i++) begin
            sel = int'($urandom_range(0, 7));
            r = 9'($urandom_range(0, 478));
            c = 10'($urandom_range(0, 1023));
            if (sel == 0) begin r = 9'd479; c = 10'($urandom_range(640, 1023)); end
            else if (sel == 1) begin r = 9'($urandom_range(480, 511)); c = 10'd639; end
            v = 1'($urandom); g = 1'($urandom); d = 1'($urandom);
            o = d ? 1'b0 : 1'($urandom);
            if (i == hit_at) begin r = 9'd200; c = 10'd50; v = 1'b1; d = 1'b1; o = 1'b1; end
            b = (press_at >= 0) && (i == press_at || i == press_at + 1);
            if (i == press_at) r = 9'd100;
            step(r, c, v, g, d, o, b);
        end
        gs_pre = game_status;
        v = 1'($urandom); g = 1'($urandom); d = 1'($urandom);
        step(9'd479, 10'd639, v, g, d, 1'b0, (press_at == n) || (press_at == n - 1));
        gs_post = game_status; coll_post = collision; tick_post = frame_tick;
    endtask

    task automatic test_reset();
        do_reset();
        run_frame(8, 2, -1);
        step(9'd12, 10'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        N_rst = 1'b0;
        row_addr = 9'd479; col_addr = 10'd639; video_on = 1'b1;
        ground_px = 1'b1; dino_px = 1'b1; obstacle_px = 1'b1; start_btn = 1'b1;
        @(posedge CLK);
        #1;
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb got=%h want=000", rgb); end
        checks++; if (game_status !== 1'b0) begin errors++; $display("FAIL reset_gs got=%b want=0", game_status); end
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL reset_coll got=%b want=0", collision); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b want=0", frame_tick); end
        start_btn = 1'b0;
        N_rst = 1'b1;
        model_reset();
        run_err = 0;
        run_frame(10, -1, -1);
        run_frame(10, -1, -1);
        checks++; if (gs_post !== 1'b0) begin errors++; $display("FAIL idle_no_start got=%b want=0", gs_post); end
        step(9'd10, 10'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (rgb !== 12'hFFF) begin errors++; $display("FAIL bg_pixel got=%h want=fff", rgb); end
        step(9'd10, 10'd11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL blank_pixel got=%h want=000", rgb); end
        step(9'd10, 10'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (rgb !== 12'h555) begin errors++; $display("FAIL fg_pixel got=%h want=555", rgb); end
        step(9'd479, 10'd639, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (run_err !== 0) begin errors++; $display("FAIL reset_scan cycles_off=%0d want=0", run_err); end
    endtask

    task automatic test_start_idle();
        run_err = 0;
        run_frame(12, 5, -1);
        checks++; if (gs_pre !== 1'b0) begin errors++; $display("FAIL start_early got=%b want=0", gs_pre); end
        checks++; if (gs_post !== 1'b1) begin errors++; $display("FAIL start_rise got=%b want=1", gs_post); end
        checks++; if (tick_post !== 1'b1) begin errors++; $display("FAIL start_tick got=%b want=1", tick_post); end
        checks++; if (run_err !== 0) begin errors++; $display("FAIL start_scan cycles_off=%0d want=0", run_err); end
    endtask

    task automatic test_collision();
        run_err = 0;
        run_frame(12, -1, 4);
        checks++; if (gs_pre !== 1'b1) begin errors++; $display("FAIL coll_pre_gs got=%b want=1", gs_pre); end
        checks++; if (coll_post !== 1'b1) begin errors++; $display("FAIL coll_pulse got=%b want=1", coll_post); end
        checks++; if (tick_post !== 1'b1) begin errors++; $display("FAIL coll_tick got=%b want=1", tick_post); end
        checks++; if (gs_post !== 1'b0) begin errors++; $display("FAIL coll_gs got=%b want=0", gs_post); end
        step(9'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL coll_one_cycle got=%b want=0", collision); end
        checks++; if (run_err !== 0) begin errors++; $display("FAIL coll_scan cycles_off=%0d want=0", run_err); end
    endtask

    task automatic test_holdoff();
        int early_runs;
        run_err = 0;
        early_runs = 0;
        for (int k = 1; k <= 29; k++) begin
            run_frame(6, 2, -1);
            if (gs_post !== 1'b0) early_runs++;
        end
        checks++; if (early_runs !== 0) begin errors++; $display("FAIL holdoff_ignore got=%0d want=0", early_runs); end
        run_frame(6, -1, -1);
        checks++; if (gs_post !== 1'b0) begin errors++; $display("FAIL holdoff_f30 got=%b want=0", gs_post); end
        run_frame(6, 2, -1);
        checks++; if (gs_pre !== 1'b0) begin errors++; $display("FAIL holdoff_f31_pre got=%b want=0", gs_pre); end
        checks++; if (gs_post !== 1'b1) begin errors++; $display("FAIL holdoff_f31 got=%b want=1", gs_post); end
        checks++; if (run_err !== 0) begin errors++; $display("FAIL holdoff_scan cycles_off=%0d want=0", run_err); end
    endtask

    task automatic test_hit_and_press();
        run_err = 0;
        run_frame(12, 3, 7);
        checks++; if (coll_post !== 1'b1) begin errors++; $display("FAIL hitpress_coll got=%b want=1", coll_post); end
        checks++; if (gs_post !== 1'b0) begin errors++; $display("FAIL hitpress_gs got=%b want=0", gs_post); end
        run_frame(6, -1, -1);
        checks++; if (gs_post !== 1'b0) begin errors++; $display("FAIL hitpress_latched got=%b want=0", gs_post); end
        checks++; if (run_err !== 0) begin errors++; $display("FAIL hitpress_scan cycles_off=%0d want=0", run_err); end
    endtask

    task automatic test_boundary_press();
        do_reset();
        run_err = 0;
        run_frame(6, 6, -1);
        checks++; if (gs_pre !== 1'b0) begin errors++; $display("FAIL bpress_pre got=%b want=0", gs_pre); end
        checks++; if (gs_post !== 1'b1) begin errors++; $display("FAIL bpress_run got=%b want=1", gs_post); end
        checks++; if (run_err !== 0) begin errors++; $display("FAIL bpress_scan cycles_off=%0d want=0", run_err); end
    endtask

    task automatic test_out_of_range();
        step(9'd480, 10'd639, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL oor_row got=%b want=0", frame_tick); end
        step(9'd479, 10'd640, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL oor_col got=%b want=0", frame_tick); end
        step(9'd511, 10'd1023, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL oor_max got=%b want=0", frame_tick); end
        step(9'd479, 10'd639, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL last_px_tick got=%b want=1", frame_tick); end
    endtask

    task automatic test_random();
        int p, h;
        run_err = 0;
        for (int k = 0; k < 40; k++) begin
            p = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 10));
            h = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 9)) : -1;
            run_frame(10, p, h);
        end
        checks++; if (run_err !== 0) begin errors++; $display("FAIL random_frames cycles_off=%0d want=0", run_err); end
    endtask

    initial begin
        test_reset();
        test_start_idle();
        test_collision();
        test_holdoff();
        test_hit_and_press();
        test_boundary_press();
        test_out_of_range();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_compositor.md
Name: frame_compositor

Overview:
- Downstream consumer of the ground pixel stream; also merges the dino and obstacle pixel streams into one 12-bit RGB pixel for the VGA output stage.
- Detects dino/obstacle overlap and owns the game state machine.
- Drives game_status, which the ground, dino and obstacle stages use: 1 means run, 0 means hold in reset pattern.

Parameters:
- LAST_ROW, 9'd479, last visible row_addr of a frame
- LAST_COL, 10'd639, last visible col_addr of a row
- HOLDOFF_FRAMES, 6'd30, frames after game over during which start is ignored
- FG_RGB, 12'h555, colour of ground/dino/obstacle pixels
- BG_RGB, 12'hFFF, background colour

Ports:
- CLK  in  1  pixel clock, single clock domain
- N_rst  in  1  reset; synchronous, active-low
- row_addr  in  9  current row, aligned with the px inputs
- col_addr  in  10  current column, aligned with the px inputs
- video_on  in  1  visible-area flag, aligned with the px inputs
- ground_px  in  1  ground pixel, 1 = foreground
- dino_px  in  1  dino pixel
- obstacle_px  in  1  obstacle pixel
- start_btn  in  1  level from the jump/start key, already synchronised
- game_status  out  1  1 in RUNNING, else 0
- collision  out  1  one-cycle pulse when game over is committed
- frame_tick  out  1  one-cycle pulse at the last visible pixel of a frame
- rgb  out  12  registered output pixel {R4,G4,B4}

Behaviour:
- Reset (N_rst=0 at a CLK edge) sets: state=IDLE, game_status=0, collision=0, frame_tick=0, rgb=12'h000, hit_flag=0, holdoff=0, btn_q=0. Reset mid-frame or mid-game aborts immediately; there is no frame-boundary wait.
- Pixel path:
  - rgb is registered with 1-cycle latency from the inputs.
  - video_on=0 gives rgb=0.
  - Otherwise, if (ground_px|dino_px|obstacle_px) then rgb=FG_RGB, else rgb=BG_RGB.
  - The pixel path operates in every state.
- frame_tick: registered, 1 cycle after the inputs show row_addr==LAST_ROW && col_addr==LAST_COL.
- Start edge: start_rise = start_btn & ~btn_q; btn_q is updated every cycle.
- hit_flag:
  - Set in RUNNING when video_on & dino_px & obstacle_px.
  - Sticky until the frame boundary.
  - Cleared at every frame boundary and on any state change.
- State machine; transitions occur only on the cycle frame_tick is generated (the frame boundary), so each frame is rendered in one consistent state:
  - IDLE: a start_rise seen at any time during the frame is latched in start_pend. At the boundary, if start_pend=1, go to RUNNING. start_pend clears on the transition.
  - RUNNING: at the boundary, if hit_flag=1, go to OVER. collision pulses 1 cycle concurrent with frame_tick, and holdoff loads HOLDOFF_FRAMES.
  - OVER: holdoff decrements each boundary, saturating at 0. start_rise is latched in start_pend only while holdoff==0. At the boundary, if start_pend=1, go to RUNNING; the ground stage re-initialises because game_status was 0.
- Simultaneous events:
  - A hit and a start press in the same RUNNING frame: the hit wins and the press is discarded.
  - A start_rise on the boundary cycle itself counts toward the frame just ending.
- game_status = (state==RUNNING), registered, and changes 1 cycle after the boundary input cycle (same cycle as frame_tick).
- Width rules:
  - holdoff is 6 bits.
  - Address compares are full width with no modulo.
  - Addresses beyond LAST_ROW/LAST_COL never generate frame_tick.

Optional Feature:
- Macro GAMEOVER_FLASH_EN.
- When defined: a 5-bit frame counter runs in OVER and clears on entry to OVER. While its MSB=1, visible pixels use swapped colours (FG_RGB and BG_RGB exchange roles), giving a 16-frame flash.
- When undefined: the counter is absent and OVER renders identically to RUNNING.

Decomposition:
- Package dino_pkg holds:
  - the state enum {IDLE, RUNNING, OVER} (2-bit)
  - the default colour constants
  - the LAST_ROW/LAST_COL defaults
- One natural sub-module: frame_boundary, which takes the address compare and produces the registered frame_tick.
- Edge detect and the FSM stay in the top module.

Test Plan:
- Reset mid-frame, release, then a 2-frame scan with no start -> game_status=0 throughout; rgb=12'hFFF on visible background and 12'h000 when video_on=0.
- In IDLE, pulse start_btn at row 100 -> game_status rises exactly 1 cycle after the row 479 / col 639 input cycle; no earlier change.
- In RUNNING, drive dino_px=obstacle_px=1 at row 200, col 50 for 1 cycle -> collision pulse coincident with the next frame_tick; game_status=0 from that cycle.
- In OVER with HOLDOFF_FRAMES=30, press start in frames 1..29 -> ignored; press in frame 31 -> RUNNING at the end of frame 31.
- In RUNNING, hit and start press in the same frame -> OVER, collision=1, start not latched.
- With GAMEOVER_FLASH_EN defined, in OVER frames 16..31 with background pixel -> rgb=12'h555; ground pixel -> rgb=12'hFFF.
